// File: rtl/alu_mdu.sv
// RV32M-style multiply/divide unit: one-cycle full-width multiply, iterative restoring divide.
// A single request is in flight at a time; the result is held until it is consumed.
module alu_mdu #(
    parameter int WIDTH    = 32,
    parameter int DIV_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int XW    = 2 * WIDTH + 1;
    localparam int STEPS = WIDTH / DIV_STEP;
    localparam int CW    = $clog2(STEPS) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic               neg_q, neg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               sgn_in;
    logic [WIDTH-1:0]   abs_a_in;
    logic               div_by_zero;
    logic               div_ovf;

    logic               a_sgn, b_sgn;
    logic [XW-1:0]      a_ext, b_ext, prod;
    logic               unused_prod_msb;

    logic [WIDTH-1:0]   div_mag;
    logic [WIDTH-1:0]   rem_v, quo_v;
    logic [WIDTH:0]     trial;

    // Operands sign-extended (or zero-extended) to 2*WIDTH+1 bits so one multiplier covers all four ops.
    assign a_sgn           = op_q[1] ^ op_q[0];
    assign b_sgn           = (op_q == 3'd1);
    assign a_ext           = {{(WIDTH + 1){a_q[WIDTH-1] & a_sgn}}, a_q};
    assign b_ext           = {{(WIDTH + 1){b_q[WIDTH-1] & b_sgn}}, b_q};
    assign prod            = a_ext * b_ext;
    assign unused_prod_msb = prod[XW-1];

    assign div_mag     = (!op_q[0] && b_q[WIDTH-1]) ? -b_q : b_q;
    assign sgn_in      = !op[0];
    assign abs_a_in    = (sgn_in && a[WIDTH-1]) ? -a : a;
    assign div_by_zero = (b == '0);
    assign div_ovf     = sgn_in && (a == {1'b1, {(WIDTH - 1){1'b0}}}) && (b == '1);

    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise paths that skip it infer latches.
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rem_v    = rem_q;
        quo_v    = quo_q;
        trial    = '0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d  = op;
                    a_d   = a;
                    b_d   = b;
                    rem_d = '0;
                    quo_d = abs_a_in;
                    cnt_d = '0;
                    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
                    neg_d = op[1] ? (sgn_in & a[WIDTH-1])
                                  : (sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]));
                    if (!op[2]) begin
                        state_d = S_MUL;
                    end else if (div_by_zero) begin
                        result_d = op[1] ? a : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = op[1] ? '0 : a;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                result_d = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
                state_d  = S_DONE;
            end
            S_DIV: begin
                for (int i = 0; i < DIV_STEP; i++) begin
                    trial = {rem_v, quo_v[WIDTH-1]};
                    quo_v = {quo_v[WIDTH-2:0], 1'b0};
                    if (trial >= {1'b0, div_mag}) begin
                        rem_v    = trial[WIDTH-1:0] - div_mag;
                        quo_v[0] = 1'b1;
                    end else begin
                        rem_v = trial[WIDTH-1:0];
                    end
                end
                rem_d = rem_v;
                quo_d = quo_v;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1)) begin
                    if (op_q[1]) begin
                        result_d = neg_q ? -rem_v : rem_v;
                    end else begin
                        result_d = neg_q ? -quo_v : quo_v;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A squash discards whatever was in progress, including a result about to land.
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (WIDTH=32, DIV_STEP=1): directed corner cases plus
// random requests compared against a plain-arithmetic RV32M reference model.
module tb_alu_mdu;

    localparam int W = 32;
    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;

    int errors = 0;
    int checks = 0;

    alu_mdu #(.WIDTH(W), .DIV_STEP(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: RV32M results from ordinary integer arithmetic.
    function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        int          ix, iy;
        logic        ovf;
        sx  = $signed(x);
        sy  = $signed(y);
        ux  = longint'({32'b0, x});
        uy  = longint'({32'b0, y});
        ix  = $signed(x);
        iy  = $signed(y);
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            OP_MUL:    begin p = sx * sy; return p[31:0];  end
            OP_MULH:   begin p = sx * sy; return p[63:32]; end
            OP_MULHSU: begin p = sx * uy; return p[63:32]; end
            OP_MULHU:  begin p = ux * uy; return p[63:32]; end
            OP_DIV:    return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(ix / iy);
            OP_DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
            OP_REM:    return (y == 0) ? x : ovf ? 32'd0 : 32'(ix % iy);
            default:   return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        if (!o[2]) return 2;
        if (y == 0) return 1;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    // Presents one request; returns at the sample point one cycle after the accept edge.
    task automatic accept(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        chk("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int hold);
        logic [W-1:0] exp;
        int           lat;
        exp = model(o, x, y);
        out_ready = 1'b0;
        accept(o, x, y);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, model_lat(o, x, y));
        chk({tag, "_result"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_result"}, result, exp);
            chk({tag, "_hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle_in_ready"}, in_ready, 1);
        chk({tag, "_idle_valid"}, out_valid, 0);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_result"}, result, exp);
    endtask

    initial begin
        logic         seen;
        logic [2:0]   r_op;
        logic [W-1:0] r_a, r_b;
        int           sel;

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        chk("reset_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_result", result, 0);
        rst = 1'b0;
        chk("first_cycle_in_ready", in_ready, 1);

        run_op("mulh_min_min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem_neg7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu_by_zero", OP_DIVU, 32'd5, 32'd0, 0);
        run_op("remu_by_zero", OP_REMU, 32'd5, 32'd0, 0);
        run_op("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_overflow", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("mul_hold5", OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5);
        run_op("mulhsu_neg", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd7, 2);

        // Flush ten cycles into a divide: the result must never appear.
        out_ready = 1'b1;
        accept(OP_DIV, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        chk("flush_mid_div_busy_before", busy, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_valid", out_valid, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk("flush_valid_never", seen, 0);
        run_op("mulhu_after_flush", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        // Flush beats a simultaneous request.
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        op       = OP_MUL;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_blocks_accept", busy, 0);

        // Reset ten cycles into a divide, with a request pending in the reset cycle.
        accept(OP_DIV, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        op       = OP_MUL;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_mid_div_result", result, 0);
        chk("rst_mid_div_valid", out_valid, 0);
        chk("rst_mid_div_busy", busy, 0);
        chk("rst_mid_div_in_ready", in_ready, 1);
        @(negedge clk);
        chk("rst_no_accept", busy, 0);

        for (int n = 0; n < 40; n++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            sel  = $urandom_range(0, 9);
            if (sel == 0) r_b = '0;
            if (sel == 1) begin
                r_a = 32'h8000_0000;
                r_b = 32'hFFFF_FFFF;
            end
            if (sel == 2) r_b = 32'($urandom_range(1, 15));
            if (sel == 3) r_b = -32'($urandom_range(1, 15));
            run_op("random", r_op, r_a, r_b, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
